// File: rtl/eth_pkt_prefetch_fifo.sv
// eth_pkt_prefetch_fifo: single-clock FIFO built on a block RAM with a
// first-word-fall-through output register. In packet mode, words stay
// invisible to the reader until the word carrying wr_last has been written,
// and a partly written packet can be thrown away with wr_drop.
module eth_pkt_prefetch_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 7,
  parameter int AFULL_TH    = 120,
  parameter int AEMPTY_TH   = 4,
  parameter int PKT_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_last,
  input  logic                   wr_drop,
  output logic                   wr_vld,
  input  logic                   rd_en,
  output logic                   rd_vld,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_last,
  output logic [DEPTH_WIDTH:0]   level,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   ovf
);

  localparam int              PW        = DEPTH_WIDTH + 1;
  localparam int              RAM_WORDS = 1 << DEPTH_WIDTH;
  localparam bit              PKT       = (PKT_MODE != 0);
  localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
  localparam logic [31:0]     AFULL_U   = AFULL_TH;
  localparam logic [31:0]     AEMPTY_U  = AEMPTY_TH;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  // Storage: each RAM word carries the data plus its wr_last flag in the MSB.
  logic [DATA_WIDTH:0] mem [0:RAM_WORDS-1];

  // Reset synchroniser: assertion is immediate, release is delayed two clocks.
  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  // Pointers: one extra MSB so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] cm_ptr_q, cm_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  state_t state_q, state_d;

  logic                ovf_q, ovf_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic [DATA_WIDTH:0] rd_word_q;

  logic ram_full;
  logic ram_has_data;
  logic wr_accept;
  logic pop;
  logic load;

  // Two-flop synchroniser releasing the internal reset on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[1];

  // RAM occupancy includes uncommitted words; committed data is what the
  // reader is allowed to fetch.
  assign ram_full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign ram_has_data = (cm_ptr_q != rd_ptr_q);

  // wr_vld stays low while the internal reset is still being released.
  assign wr_vld = rst_sync_n && !ram_full;
  assign rd_vld = (state_q == S_VALID);
  assign pop    = rd_en && rd_vld;

  // Committed words waiting in RAM plus the word held in the output register.
  assign level  = (cm_ptr_q - rd_ptr_q) + {{(PW-1){1'b0}}, rd_vld};

  // Write side: accept, commit and packet drop pointer updates.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    wr_accept = 1'b0;
    ovf_d     = wr_en && !wr_vld;
    if (PKT && wr_drop) begin
      // Drop has priority over a simultaneous write; that word is lost too.
      wr_ptr_d = cm_ptr_q;
    end else if (wr_en && wr_vld) begin
      wr_accept = 1'b1;
      wr_ptr_d  = wr_ptr_q + PTR_ONE;
      if (!PKT || wr_last) begin
        cm_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end
  end

  // Prefetch FSM next state; a pop in VALID overlaps the next RAM read so a
  // continuous reader gets one word per clock.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (ram_has_data) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        load    = 1'b1;
        state_d = S_VALID;
      end
      S_VALID: begin
        if (pop) begin
          if (ram_has_data) begin
            load = 1'b1;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    rd_ptr_d = load ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  // Threshold flags are computed from the current level and registered.
  always_comb begin
    afull_d  = (32'(level) >= AFULL_U);
    aempty_d = (32'(level) <= AEMPTY_U);
  end

  // RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= {wr_last, wr_data};
    end
  end

  // Control state, flags and the output register (RAM registered read).
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wr_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= S_EMPTY;
      ovf_q     <= 1'b0;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      rd_word_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      ovf_q    <= ovf_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      if (load) begin
        rd_word_q <= mem[rd_ptr_q[DEPTH_WIDTH-1:0]];
      end
    end
  end

  assign rd_data      = rd_word_q[DATA_WIDTH-1:0];
  assign rd_last      = rd_word_q[DATA_WIDTH];
  assign ovf          = ovf_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

endmodule

// File: tb/tb_eth_pkt_prefetch_fifo.sv
// Directed self-checking bench: one word-mode and one packet-mode instance
// sharing clock and reset.
module tb_eth_pkt_prefetch_fifo;

  localparam int DW = 32;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Word-mode instance signals
  logic          w_wr_en, w_wr_last, w_wr_drop, w_rd_en;
  logic [DW-1:0] w_wr_data;
  logic          w_wr_vld, w_rd_vld, w_rd_last, w_afull, w_aempty, w_ovf;
  logic [DW-1:0] w_rd_data;
  logic [AW:0]   w_level;

  // Packet-mode instance signals
  logic          p_wr_en, p_wr_last, p_wr_drop, p_rd_en;
  logic [DW-1:0] p_wr_data;
  logic          p_wr_vld, p_rd_vld, p_rd_last, p_afull, p_aempty, p_ovf;
  logic [DW-1:0] p_rd_data;
  logic [AW:0]   p_level;

  int n_checks = 0;
  int n_fail   = 0;

  // Test 1 table: per cycle after each edge
  logic [DW-1:0] t1_wdata [0:5] = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0};
  logic          t1_vld   [0:5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [DW-1:0] t1_rdata [0:5] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
  logic [AW:0]   t1_lvl   [0:5] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0};

  eth_pkt_prefetch_fifo #(
    .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .AFULL_TH(120), .AEMPTY_TH(4), .PKT_MODE(0)
  ) u_dut_word (
    .clk(clk), .rst_n(rst_n),
    .wr_en(w_wr_en), .wr_data(w_wr_data), .wr_last(w_wr_last), .wr_drop(w_wr_drop),
    .wr_vld(w_wr_vld), .rd_en(w_rd_en), .rd_vld(w_rd_vld), .rd_data(w_rd_data),
    .rd_last(w_rd_last), .level(w_level), .almost_full(w_afull),
    .almost_empty(w_aempty), .ovf(w_ovf)
  );

  eth_pkt_prefetch_fifo #(
    .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .AFULL_TH(120), .AEMPTY_TH(4), .PKT_MODE(1)
  ) u_dut_pkt (
    .clk(clk), .rst_n(rst_n),
    .wr_en(p_wr_en), .wr_data(p_wr_data), .wr_last(p_wr_last), .wr_drop(p_wr_drop),
    .wr_vld(p_wr_vld), .rd_en(p_rd_en), .rd_vld(p_rd_vld), .rd_data(p_rd_data),
    .rd_last(p_rd_last), .level(p_level), .almost_full(p_afull),
    .almost_empty(p_aempty), .ovf(p_ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    w_wr_en = 1'b0; w_wr_last = 1'b0; w_wr_drop = 1'b0; w_rd_en = 1'b0; w_wr_data = '0;
    p_wr_en = 1'b0; p_wr_last = 1'b0; p_wr_drop = 1'b0; p_rd_en = 1'b0; p_wr_data = '0;
  endtask

  // Hang guard
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int widx;
    int ridx;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    check_eq("rst_rd_vld", 64'(w_rd_vld), 64'd0);
    check_eq("rst_level", 64'(w_level), 64'd0);
    check_eq("rst_aempty", 64'(w_aempty), 64'd1);
    check_eq("rst_afull", 64'(w_afull), 64'd0);
    check_eq("rst_ovf", 64'(w_ovf), 64'd0);
    check_eq("rst_rd_data", 64'(w_rd_data), 64'd0);
    check_eq("rst_rd_last", 64'(w_rd_last), 64'd0);
    check_eq("rst_p_rd_vld", 64'(p_rd_vld), 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_sync_hold", 64'(w_wr_vld), 64'd0);
    tick();
    check_eq("rst_wr_vld", 64'(w_wr_vld), 64'd1);
    check_eq("rst_p_wr_vld", 64'(p_wr_vld), 64'd1);
    $display("reset released");

    // ---------------- three words, latency and back-to-back pops ----------------
    for (int k = 0; k < 6; k++) begin
      w_wr_en   = (k < 3);
      w_wr_data = t1_wdata[k];
      w_rd_en   = 1'b1;
      tick();
      check_eq($sformatf("t1_vld[%0d]", k), 64'(w_rd_vld), 64'(t1_vld[k]));
      if (t1_vld[k]) begin
        check_eq($sformatf("t1_data[%0d]", k), 64'(w_rd_data), 64'(t1_rdata[k]));
        $display("t1 rd 0x%08h", w_rd_data);
      end
      check_eq($sformatf("t1_level[%0d]", k), 64'(w_level), 64'(t1_lvl[k]));
    end
    // rd_en while empty is harmless
    w_wr_en = 1'b0;
    tick();
    check_eq("empty_rd_vld", 64'(w_rd_vld), 64'd0);
    check_eq("empty_level", 64'(w_level), 64'd0);
    check_eq("empty_ovf", 64'(w_ovf), 64'd0);

    // ---------------- output stability without pop ----------------
    w_rd_en = 1'b0;
    w_wr_en = 1'b1; w_wr_data = 32'h5A; w_wr_last = 1'b1;
    tick();
    w_wr_en = 1'b0; w_wr_last = 1'b0; w_wr_data = 32'hFFFF_FFFF;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("hold_vld[%0d]", k), 64'(w_rd_vld), 64'd1);
      check_eq($sformatf("hold_data[%0d]", k), 64'(w_rd_data), 64'h5A);
      check_eq($sformatf("hold_last[%0d]", k), 64'(w_rd_last), 64'd1);
      tick();
    end
    w_rd_en = 1'b1;
    tick();
    w_rd_en = 1'b0;
    check_eq("hold_pop_vld", 64'(w_rd_vld), 64'd0);
    check_eq("hold_pop_level", 64'(w_level), 64'd0);
    $display("hold word 0x5A popped");

    // ---------------- fill to full, overflow, drain ----------------
    cnt = 0;
    for (int i = 0; i < 200 && w_wr_vld; i++) begin
      w_wr_en   = 1'b1;
      w_wr_data = 32'(i);
      tick();
      cnt++;
      if (cnt == 128) check_eq("fill_level128", 64'(w_level), 64'd128);
    end
    check_eq("fill_accepted", 64'(cnt), 64'd129);
    check_eq("fill_wr_vld", 64'(w_wr_vld), 64'd0);
    check_eq("fill_level129", 64'(w_level), 64'd129);
    check_eq("fill_afull", 64'(w_afull), 64'd1);
    check_eq("fill_ovf_before", 64'(w_ovf), 64'd0);
    tick();
    check_eq("fill_ovf_pulse", 64'(w_ovf), 64'd1);
    w_wr_en = 1'b0;
    tick();
    check_eq("fill_ovf_clear", 64'(w_ovf), 64'd0);
    check_eq("fill_level_after_ovf", 64'(w_level), 64'd129);
    $display("fill: %0d words accepted", cnt);
    w_rd_en = 1'b1;
    for (int j = 0; j < 129; j++) begin
      check_eq($sformatf("drain_vld[%0d]", j), 64'(w_rd_vld), 64'd1);
      check_eq($sformatf("drain_data[%0d]", j), 64'(w_rd_data), 64'(j));
      check_eq($sformatf("drain_afull[%0d]", j), 64'(w_afull), 64'((130 - j) >= 120));
      check_eq($sformatf("drain_aempty[%0d]", j), 64'(w_aempty), 64'((130 - j) <= 4));
      tick();
    end
    w_rd_en = 1'b0;
    check_eq("drain_end_vld", 64'(w_rd_vld), 64'd0);
    check_eq("drain_end_level", 64'(w_level), 64'd0);
    check_eq("drain_end_aempty", 64'(w_aempty), 64'd1);
    $display("drain: 129 words read");

    // ---------------- packet mode: commit on last ----------------
    for (int k = 0; k < 6; k++) begin
      p_wr_en   = (k < 4);
      p_wr_data = 32'hA0 + 32'(k);
      p_wr_last = (k == 3);
      tick();
      check_eq($sformatf("pkt_vld[%0d]", k), 64'(p_rd_vld), 64'(k == 5));
      check_eq($sformatf("pkt_level[%0d]", k), 64'(p_level), (k >= 3) ? 64'd4 : 64'd0);
    end
    p_wr_en = 1'b0; p_wr_last = 1'b0;
    p_rd_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check_eq($sformatf("pkt_rd_vld[%0d]", j), 64'(p_rd_vld), 64'd1);
      check_eq($sformatf("pkt_rd_data[%0d]", j), 64'(p_rd_data), 64'(32'hA0 + 32'(j)));
      check_eq($sformatf("pkt_rd_last[%0d]", j), 64'(p_rd_last), 64'(j == 3));
      $display("pkt rd 0x%08h last %0d", p_rd_data, p_rd_last);
      tick();
    end
    p_rd_en = 1'b0;
    check_eq("pkt_end_vld", 64'(p_rd_vld), 64'd0);
    check_eq("pkt_end_level", 64'(p_level), 64'd0);

    // ---------------- packet mode: drop wins over write ----------------
    for (int k = 0; k < 3; k++) begin
      p_wr_en = 1'b1; p_wr_data = 32'hC0 + 32'(k);
      tick();
    end
    check_eq("drop_pre_level", 64'(p_level), 64'd0);
    p_wr_en = 1'b1; p_wr_drop = 1'b1; p_wr_last = 1'b1; p_wr_data = 32'hDEAD;
    tick();
    p_wr_en = 1'b0; p_wr_drop = 1'b0; p_wr_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("drop_vld[%0d]", k), 64'(p_rd_vld), 64'd0);
      check_eq($sformatf("drop_level[%0d]", k), 64'(p_level), 64'd0);
      check_eq($sformatf("drop_wr_vld[%0d]", k), 64'(p_wr_vld), 64'd1);
      tick();
    end
    p_wr_en = 1'b1; p_wr_data = 32'hB7; p_wr_last = 1'b1;
    tick();
    p_wr_en = 1'b0; p_wr_last = 1'b0;
    tick(); tick();
    check_eq("drop_next_vld", 64'(p_rd_vld), 64'd1);
    check_eq("drop_next_data", 64'(p_rd_data), 64'hB7);
    check_eq("drop_next_last", 64'(p_rd_last), 64'd1);
    check_eq("drop_next_level", 64'(p_level), 64'd1);
    $display("drop: next packet rd 0x%08h", p_rd_data);
    p_rd_en = 1'b1;
    tick();
    p_rd_en = 1'b0;
    check_eq("drop_next_pop", 64'(p_rd_vld), 64'd0);

    // ---------------- wrap: 300 words with random stalls ----------------
    widx = 0;
    ridx = 0;
    for (int cyc = 0; cyc < 5000 && ridx < 300; cyc++) begin
      w_wr_en   = (widx < 300) && ($urandom_range(0, 3) != 0);
      w_wr_data = 32'h1000 + 32'(widx);
      w_rd_en   = ($urandom_range(0, 1) != 0);
      if (w_wr_en && w_wr_vld) widx++;
      if (w_rd_en && w_rd_vld) begin
        check_eq($sformatf("wrap_data[%0d]", ridx), 64'(w_rd_data), 64'(32'h1000 + 32'(ridx)));
        $display("wrap rd %0d 0x%08h", ridx, w_rd_data);
        ridx++;
      end
      tick();
    end
    w_wr_en = 1'b0; w_rd_en = 1'b0;
    check_eq("wrap_written", 64'(widx), 64'd300);
    check_eq("wrap_read", 64'(ridx), 64'd300);
    tick(); tick();
    check_eq("wrap_end_level", 64'(w_level), 64'd0);
    check_eq("wrap_end_vld", 64'(w_rd_vld), 64'd0);

    // ---------------- reset while VALID with 10 words ----------------
    for (int k = 0; k < 10; k++) begin
      w_wr_en = 1'b1; w_wr_data = 32'h200 + 32'(k);
      tick();
    end
    w_wr_en = 1'b0;
    tick(); tick();
    check_eq("mid_level", 64'(w_level), 64'd10);
    check_eq("mid_vld", 64'(w_rd_vld), 64'd1);
    check_eq("mid_data", 64'(w_rd_data), 64'h200);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_vld", 64'(w_rd_vld), 64'd0);
    check_eq("arst_level", 64'(w_level), 64'd0);
    check_eq("arst_data", 64'(w_rd_data), 64'd0);
    check_eq("arst_aempty", 64'(w_aempty), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("arst_sync_hold", 64'(w_wr_vld), 64'd0);
    tick();
    check_eq("arst_wr_vld", 64'(w_wr_vld), 64'd1);
    check_eq("arst_level_rel", 64'(w_level), 64'd0);
    check_eq("arst_vld_rel", 64'(w_rd_vld), 64'd0);
    w_wr_en = 1'b1; w_wr_data = 32'hA5;
    tick();
    w_wr_en = 1'b0;
    tick(); tick();
    check_eq("post_rst_vld", 64'(w_rd_vld), 64'd1);
    check_eq("post_rst_data", 64'(w_rd_data), 64'hA5);
    check_eq("post_rst_level", 64'(w_level), 64'd1);
    $display("post-reset rd 0x%08h", w_rd_data);
    w_rd_en = 1'b1;
    tick();
    w_rd_en = 1'b0;
    check_eq("post_rst_pop_vld", 64'(w_rd_vld), 64'd0);
    check_eq("post_rst_pop_level", 64'(w_level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
